unified_mem_arbiter: RTL

//   Shares one single-ported unified memory between the pipeline's IF stage (instruction fetch) and MEM stage (load/store).

---
 rtl/unified_mem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the data port.
// Data has fixed priority; each access is a req/ready transaction with a timeout guard.
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t            r_state, w_state;
  logic [CNT_W-1:0]  r_cnt, w_cnt, w_cnt_inc;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata, r_d_rdata, w_d_rdata;
  logic              r_if_ack, w_if_ack, r_d_ack, w_d_ack;
  logic              r_mem_req, w_mem_req, r_mem_we, w_mem_we;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic              r_err, w_err;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_if_rdata  <= w_if_rdata;
      r_d_rdata   <= w_d_rdata;
      r_if_ack    <= w_if_ack;
      r_d_ack     <= w_d_ack;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_err       <= w_err;
    end
  end

  // Next-state and next-output logic; acks are single-cycle pulses by default
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_if_rdata  = r_if_rdata;
    w_d_rdata   = r_d_rdata;
    w_if_ack    = 1'b0;
    w_d_ack     = 1'b0;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_err       = r_err;
    case (r_state)
      IDLE: begin
        // A port still showing its ack is the requester that has not yet dropped req
        if (d_req && !r_d_ack) begin
          w_state     = GRANT_D;
          w_cnt       = '0;
          w_mem_req   = 1'b1;
          w_mem_we    = d_we;
          w_mem_addr  = d_addr;
          w_mem_wdata = d_wdata;
        end else if (if_req && !r_if_ack) begin
          w_state     = GRANT_I;
          w_cnt       = '0;
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b0;
          w_mem_addr  = if_addr;
          w_mem_wdata = '0;
        end else begin
          w_state = IDLE;
        end
      end
      GRANT_I, GRANT_D: begin
        w_cnt = w_cnt_inc;
        if (mem_ready) begin
          w_state   = IDLE;
          w_mem_req = 1'b0;
          if (r_state == GRANT_I) begin
            w_if_ack   = 1'b1;
            w_if_rdata = mem_rdata;
          end else begin
            w_d_ack = 1'b1;
            if (!r_mem_we) begin
              w_d_rdata = mem_rdata;
            end else begin
              w_d_rdata = r_d_rdata;
            end
          end
        end else if (w_cnt_inc == CNT_W'(TIMEOUT)) begin
          w_state   = IDLE;
          w_mem_req = 1'b0;
          w_err     = 1'b1;
          if (r_state == GRANT_I) begin
            w_if_ack   = 1'b1;
            w_if_rdata = '0;
          end else begin
            w_d_ack   = 1'b1;
            w_d_rdata = '0;
          end
        end else begin
          w_state = r_state;
        end
      end
      default: begin
        w_state   = IDLE;
        w_mem_req = 1'b0;
      end
    endcase
  end

  assign if_rdata    = r_if_rdata;
  assign if_ack      = r_if_ack;
  assign d_rdata     = r_d_rdata;
  assign d_ack       = r_d_ack;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign timeout_err = r_err;
  assign stall_if    = if_req & ~r_if_ack;
  assign stall_mem   = d_req & ~r_d_ack;

endmodule
